// File: rtl/systolic_tile_sequencer.sv
// Weight-stationary tile job sequencer for the systolic PE array.
// Sequences weight load, input streaming with zero bubbles, result tracking through a
// tag delay line, and job completion. Optional performance counters are enabled by
// defining SYSTOLIC_SEQ_PERF_EN.
module systolic_tile_sequencer #(
    parameter int unsigned ARRAY_LAT = 256,
    parameter int unsigned WLOAD_CYC = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vecs,
    output logic             busy,
    output logic             done,
    input  logic             w_valid,
    output logic             we_rl,
    output logic             w_loaded,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             din_zero,
    output logic             out_valid,
    output logic             out_last
`ifdef SYSTOLIC_SEQ_PERF_EN
    ,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_bubbles
`endif
);

    localparam int unsigned WcntW = (WLOAD_CYC < 2) ? 1 : $clog2(WLOAD_CYC + 1);

    typedef enum logic [2:0] {
        StIdle,
        StWload,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     num_q, num_d;
    logic [CNT_W-1:0]     issued_q, issued_d;
    logic [CNT_W-1:0]     recv_q, recv_d;
    logic [WcntW-1:0]     wcnt_q, wcnt_d;
    logic [ARRAY_LAT-1:0] tag_q, tag_d;
    logic                 w_loaded_q, w_loaded_d;
    logic                 accept;
    logic                 handshake;

    // Result side: the oldest tag marks a valid result word.
    always_comb begin
        out_valid = tag_q[ARRAY_LAT-1];
        out_last  = out_valid && (recv_q == num_q - CNT_W'(1));
    end

    // Next-state and control outputs.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        issued_d   = issued_q;
        recv_d     = recv_q;
        wcnt_d     = wcnt_q;
        w_loaded_d = 1'b0;
        busy       = (state_q != StIdle);
        done       = 1'b0;
        we_rl      = 1'b0;
        in_ready   = 1'b0;
        din_zero   = 1'b1;
        handshake  = 1'b0;
        accept     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    accept   = 1'b1;
                    num_d    = num_vecs;
                    issued_d = '0;
                    recv_d   = '0;
                    wcnt_d   = '0;
                    state_d  = (num_vecs == '0) ? StDone : StWload;
                end
            end
            StWload: begin
                we_rl = w_valid;
                if (w_valid) begin
                    wcnt_d = wcnt_q + WcntW'(1);
                    // Gaps in w_valid only pause the count.
                    if (wcnt_q == WcntW'(WLOAD_CYC - 1)) begin
                        w_loaded_d = 1'b1;
                        state_d    = StStream;
                    end
                end
            end
            StStream: begin
                in_ready  = (issued_q < num_q);
                handshake = in_valid && in_ready;
                din_zero  = !handshake;
                if (handshake) begin
                    issued_d = issued_q + CNT_W'(1);
                    if (issued_q == num_q - CNT_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Last result seen this cycle means recv reaches num_q on this edge.
                if (out_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (out_valid && !accept) begin
            recv_d = recv_q + CNT_W'(1);
        end

        // Tag line shifts every cycle; a handshake injects a 1.
        tag_d = (tag_q << 1) | ARRAY_LAT'(handshake);
    end

    assign w_loaded = w_loaded_q;

    // State, counters and tag delay line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            num_q      <= '0;
            issued_q   <= '0;
            recv_q     <= '0;
            wcnt_q     <= '0;
            tag_q      <= '0;
            w_loaded_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            issued_q   <= issued_d;
            recv_q     <= recv_d;
            wcnt_q     <= wcnt_d;
            tag_q      <= tag_d;
            w_loaded_q <= w_loaded_d;
        end
    end

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_bubbles_q;

    // Job cycle and stall-bubble counters; cleared on accepted start, held after done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_cycles_q  <= '0;
            perf_bubbles_q <= '0;
        end else if (accept) begin
            perf_cycles_q  <= '0;
            perf_bubbles_q <= '0;
        end else begin
            if (busy) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if ((state_q == StStream) && in_ready && !in_valid) begin
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
            end
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Self-checking bench for systolic_tile_sequencer: directed jobs from the test plan plus
// randomized jobs, checked against a job-level expectation model.
module tb_systolic_tile_sequencer;

    localparam int unsigned ARRAY_LAT = 8;
    localparam int unsigned WLOAD_CYC = 2;
    localparam int unsigned CNT_W     = 8;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_vecs = '0;
    logic             w_valid = 1'b0;
    logic             in_valid = 1'b0;
    logic             busy, done, we_rl, w_loaded, in_ready, din_zero, out_valid, out_last;
`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0]      perf_cycles, perf_bubbles;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_q[$];   // cycles at which a result word is expected
    int res_cnt = 0;
    int job_n = 0;
    int busy_cnt = 0;
    int bub_cnt = 0;

    systolic_tile_sequencer #(
        .ARRAY_LAT(ARRAY_LAT),
        .WLOAD_CYC(WLOAD_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .num_vecs (num_vecs),
        .busy     (busy),
        .done     (done),
        .w_valid  (w_valid),
        .we_rl    (we_rl),
        .w_loaded (w_loaded),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din_zero (din_zero),
        .out_valid(out_valid),
        .out_last (out_last)
`ifdef SYSTOLIC_SEQ_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_bubbles(perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Result expectations: a result is due ARRAY_LAT cycles after its handshake.
    task automatic check_out();
        logic ov;
        logic ol;
        int   d;
        ov = (exp_q.size() > 0) && (exp_q[0] == cyc);
        ol = 1'b0;
        if (ov) begin
            d  = exp_q.pop_front();
            ol = (res_cnt == job_n - 1);
            res_cnt++;
        end
        check_eq("out_valid", out_valid, ov);
        check_eq("out_last", out_last, ol);
    endtask

    // Inputs that must be ignored while busy.
    task automatic noise();
        start    = ($urandom_range(0, 3) == 0);
        num_vecs = CNT_W'($urandom);
    endtask

    task automatic run_job(input int n, input bit dir, input logic [31:0] wpat,
                           input logic [31:0] ipat, input int abort_drain);
        int   k;
        int   highs;
        int   issued;
        logic wv;
        logic iv;
        job_n    = n;
        res_cnt  = 0;
        busy_cnt = 0;
        bub_cnt  = 0;

        // Accept cycle in IDLE.
        start    = 1'b1;
        num_vecs = CNT_W'(n);
        w_valid  = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
        #1;
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_in_ready", in_ready, 1'b0);
        check_eq("idle_we_rl", we_rl, 1'b0);
        check_eq("idle_din_zero", din_zero, 1'b1);
        check_out();
        tick();

        if (n != 0) begin
            // Weight load: count w_valid cycles until WLOAD_CYC.
            k = 0;
            highs = 0;
            while (highs < WLOAD_CYC) begin
                noise();
                wv = dir ? wpat[k % 32] : ($urandom_range(0, 99) < 60);
                if (k >= 20) wv = 1'b1;
                w_valid  = wv;
                in_valid = 1'($urandom_range(0, 1));
                #1;
                check_eq("wl_we_rl", we_rl, wv);
                check_eq("wl_in_ready", in_ready, 1'b0);
                check_eq("wl_din_zero", din_zero, 1'b1);
                check_eq("wl_w_loaded", w_loaded, 1'b0);
                check_eq("wl_busy", busy, 1'b1);
                check_out();
                if (wv) highs++;
                k++;
                busy_cnt++;
                tick();
            end

            // Streaming.
            k = 0;
            issued = 0;
            while (issued < n) begin
                noise();
                iv = dir ? ipat[k % 32] : ($urandom_range(0, 99) < 65);
                if (k >= 4 * n + 20) iv = 1'b1;
                in_valid = iv;
                w_valid  = 1'($urandom_range(0, 1));
                #1;
                check_eq("st_in_ready", in_ready, 1'b1);
                check_eq("st_din_zero", din_zero, !iv);
                check_eq("st_we_rl", we_rl, 1'b0);
                check_eq("st_w_loaded", w_loaded, (k == 0));
                check_eq("st_busy", busy, 1'b1);
                check_eq("st_done", done, 1'b0);
                check_out();
                if (iv) begin
                    exp_q.push_back(cyc + ARRAY_LAT);
                    issued++;
                end else begin
                    bub_cnt++;
                end
                k++;
                busy_cnt++;
                tick();
            end

            // Drain until the last result is seen.
            k = 0;
            while (res_cnt < n) begin
                noise();
                in_valid = 1'($urandom_range(0, 1));
                w_valid  = 1'($urandom_range(0, 1));
                if (k == abort_drain) begin
                    rstn = 1'b0;
                    #1;
                    check_eq("rst_busy", busy, 1'b0);
                    check_eq("rst_done", done, 1'b0);
                    check_eq("rst_we_rl", we_rl, 1'b0);
                    check_eq("rst_w_loaded", w_loaded, 1'b0);
                    check_eq("rst_in_ready", in_ready, 1'b0);
                    check_eq("rst_din_zero", din_zero, 1'b1);
                    check_eq("rst_out_valid", out_valid, 1'b0);
                    check_eq("rst_out_last", out_last, 1'b0);
                    exp_q.delete();
                    start = 1'b0;
                    tick();
                    rstn = 1'b1;
                    for (int i = 0; i < 2 * ARRAY_LAT; i++) begin
                        in_valid = 1'($urandom_range(0, 1));
                        w_valid  = 1'($urandom_range(0, 1));
                        #1;
                        check_eq("post_rst_out_valid", out_valid, 1'b0);
                        check_eq("post_rst_done", done, 1'b0);
                        check_eq("post_rst_busy", busy, 1'b0);
                        tick();
                    end
                    return;
                end
                #1;
                check_eq("dr_in_ready", in_ready, 1'b0);
                check_eq("dr_din_zero", din_zero, 1'b1);
                check_eq("dr_we_rl", we_rl, 1'b0);
                check_eq("dr_busy", busy, 1'b1);
                check_eq("dr_done", done, 1'b0);
                check_out();
                k++;
                busy_cnt++;
                tick();
            end
        end

        // DONE cycle.
        noise();
        in_valid = 1'($urandom_range(0, 1));
        #1;
        check_eq("dn_done", done, 1'b1);
        check_eq("dn_busy", busy, 1'b1);
        check_eq("dn_in_ready", in_ready, 1'b0);
        check_eq("dn_we_rl", we_rl, 1'b0);
        check_out();
        busy_cnt++;
        tick();

        // Back in IDLE.
        start    = 1'b0;
        in_valid = 1'($urandom_range(0, 1));
        w_valid  = 1'($urandom_range(0, 1));
        #1;
        check_eq("post_done", done, 1'b0);
        check_eq("post_busy", busy, 1'b0);
        check_eq("post_in_ready", in_ready, 1'b0);
        check_eq("post_we_rl", we_rl, 1'b0);
        check_out();
`ifdef SYSTOLIC_SEQ_PERF_EN
        check_eq("perf_cycles", perf_cycles, busy_cnt);
        check_eq("perf_bubbles", perf_bubbles, bub_cnt);
`endif
        tick();
    endtask

    initial begin
        #1 rstn = 1'b0;
        #6;
        check_eq("rst0_busy", busy, 1'b0);
        check_eq("rst0_done", done, 1'b0);
        check_eq("rst0_we_rl", we_rl, 1'b0);
        check_eq("rst0_w_loaded", w_loaded, 1'b0);
        check_eq("rst0_in_ready", in_ready, 1'b0);
        check_eq("rst0_din_zero", din_zero, 1'b1);
        check_eq("rst0_out_valid", out_valid, 1'b0);
        check_eq("rst0_out_last", out_last, 1'b0);
        #6 rstn = 1'b1;
        tick();

        run_job(4, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_job(3, 1'b1, 32'hFFFF_FFFF, 32'b11001, -1);
        run_job(2, 1'b1, 32'b1001, 32'hFFFF_FFFF, -1);
        run_job(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_job(2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        run_job(5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(1, 20)), 1'b0, 32'h0, 32'h0, -1);
        end
        run_job(1, 1'b0, 32'h0, 32'h0, -1);
        run_job((1 << CNT_W) - 1, 1'b0, 32'h0, 32'h0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
